// File: rtl/smoke_bfm_mc_pkg.sv
// Shared constants and helpers for the multi-channel smoke increment BFM.
package smoke_bfm_mc_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_CHANNELS = 2;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_LATENCY      = 3;
  localparam int DEF_ID_WIDTH     = 8;
  localparam int DEF_INC_STEP     = 1;

  // A single channel still needs a one-bit select field.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smoke_bfm_mc_fifo.sv
// Single-channel synchronous FIFO holding {id, data} request entries.
module smoke_bfm_mc_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/smoke_bfm_mc.sv
// Multi-channel increment BFM: per-channel FIFOs, round-robin arbiter, fixed-latency pipeline.
// Optional per-channel response counters on stat_count when SMOKE_BFM_MC_STATS_EN is defined.
module smoke_bfm_mc
  import smoke_bfm_mc_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int LATENCY      = DEF_LATENCY,
  parameter int ID_WIDTH     = DEF_ID_WIDTH,
  parameter int INC_STEP     = DEF_INC_STEP
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            req_valid,
  output logic                                            req_ready,
  input  logic [chan_width(NUM_CHANNELS)-1:0]             req_chan,
  input  logic [ID_WIDTH-1:0]                             req_id,
  input  logic [DATA_WIDTH-1:0]                           req_data,
  output logic                                            rsp_valid,
  input  logic                                            rsp_ready,
  output logic [chan_width(NUM_CHANNELS)-1:0]             rsp_chan,
  output logic [ID_WIDTH-1:0]                             rsp_id,
  output logic [DATA_WIDTH-1:0]                           rsp_data,
  output logic                                            rsp_wrap,
  output logic                                            err_badchan,
  output logic [NUM_CHANNELS*($clog2(FIFO_DEPTH)+1)-1:0]  chan_level
`ifdef SMOKE_BFM_MC_STATS_EN
  ,
  output logic [NUM_CHANNELS*32-1:0]                      stat_count
`endif
);

  localparam int CW = chan_width(NUM_CHANNELS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ID_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [CW-1:0]         chan;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic                  wrap;
  } stage_t;

  logic [NUM_CHANNELS-1:0] push, pop, full, empty;
  logic [FW-1:0]           rdata [NUM_CHANNELS];
  logic [LW-1:0]           level [NUM_CHANNELS];
  logic                    chan_ok, stall;
  logic                    found_hi, found_any, grant_found;
  logic [CW-1:0]           grant_hi, grant_lo, grant;
  logic [CW-1:0]           ptr_q, ptr_d;
  logic [FW-1:0]           grant_entry;
  logic [DATA_WIDTH:0]     sum;
  stage_t                  pipe_q [LATENCY];
  stage_t                  pipe_d [LATENCY];
  logic                    err_q, err_d;

  assign chan_ok = (int'(req_chan) < NUM_CHANNELS);
  assign stall   = pipe_q[LATENCY-1].valid && !rsp_ready;

  // Out-of-range channels are always accepted so the caller never blocks on them.
  always_comb begin
    req_ready = 1'b1;
    push      = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (chan_ok && (req_chan == CW'(i))) begin
        req_ready = !full[i];
        push[i]   = req_valid && !full[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    smoke_bfm_mc_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push[g]),
      .pop     (pop[g]),
      .wdata   ({req_id, req_data}),
      .rdata   (rdata[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .level   (level[g])
    );
  end

  // Lowest non-empty channel above the pointer wins, else the lowest overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    grant_hi  = '0;
    grant_lo  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        if (CW'(i) > ptr_q) begin
          found_hi = 1'b1;
          grant_hi = CW'(i);
        end
        found_any = 1'b1;
        grant_lo  = CW'(i);
      end
    end
    grant_found = found_any;
    grant       = found_hi ? grant_hi : grant_lo;
  end

  always_comb begin
    grant_entry = '0;
    pop         = '0;
    ptr_d       = ptr_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant_found && (grant == CW'(i))) begin
        grant_entry = rdata[i];
        pop[i]      = !stall;
      end
    end
    if (grant_found && !stall) begin
      ptr_d = grant;
    end
  end

  always_comb begin
    sum    = {1'b0, grant_entry[DATA_WIDTH-1:0]} + (DATA_WIDTH+1)'(INC_STEP);
    pipe_d = pipe_q;
    if (!stall) begin
      pipe_d[0] = '0;
      if (grant_found) begin
        pipe_d[0].valid = 1'b1;
        pipe_d[0].chan  = grant;
        pipe_d[0].id    = grant_entry[FW-1:DATA_WIDTH];
        pipe_d[0].data  = sum[DATA_WIDTH-1:0];
        pipe_d[0].wrap  = sum[DATA_WIDTH];
      end
      for (int s = 1; s < LATENCY; s++) begin
        pipe_d[s] = pipe_q[s-1];
      end
    end
  end

  assign err_d = req_valid && !chan_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= CW'(NUM_CHANNELS - 1);
      pipe_q <= '{default: '0};
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pipe_q <= pipe_d;
      err_q  <= err_d;
    end
  end

  assign rsp_valid   = pipe_q[LATENCY-1].valid;
  assign rsp_chan    = pipe_q[LATENCY-1].chan;
  assign rsp_id      = pipe_q[LATENCY-1].id;
  assign rsp_data    = pipe_q[LATENCY-1].data;
  assign rsp_wrap    = pipe_q[LATENCY-1].wrap;
  assign err_badchan = err_q;

  always_comb begin
    chan_level = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      chan_level[i*LW +: LW] = level[i];
    end
  end

`ifdef SMOKE_BFM_MC_STATS_EN
  logic [31:0] stat_q [NUM_CHANNELS];
  logic [31:0] stat_d [NUM_CHANNELS];

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rsp_valid && rsp_ready && (rsp_chan == CW'(i))) begin
        stat_d[i] = stat_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '{default: '0};
    end else begin
      stat_q <= stat_d;
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      stat_count[i*32 +: 32] = stat_q[i];
    end
  end
`else
  // Counter build option off: no per-channel response statistics.
`endif

endmodule

// File: tb/tb_smoke_bfm_mc.sv
// Bench for smoke_bfm_mc: queue-based reference model, per-cycle compare, directed scenarios.
module tb_smoke_bfm_mc;

  localparam int NC  = 3;
  localparam int FD  = 4;
  localparam int LAT = 3;
  localparam int CW  = 2;
  localparam int LW  = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CW-1:0]     req_chan = '0;
  logic [7:0]        req_id = '0;
  logic [31:0]       req_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [CW-1:0]     rsp_chan;
  logic [7:0]        rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_wrap;
  logic              err_badchan;
  logic [NC*LW-1:0]  chan_level;

  smoke_bfm_mc #(
    .DATA_WIDTH   (32),
    .NUM_CHANNELS (NC),
    .FIFO_DEPTH   (FD),
    .LATENCY      (LAT),
    .ID_WIDTH     (8),
    .INC_STEP     (1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_chan    (req_chan),
    .req_id      (req_id),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_chan    (rsp_chan),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_wrap    (rsp_wrap),
    .err_badchan (err_badchan),
    .chan_level  (chan_level)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending requests in arrival order, a grant pointer and LAT response slots.
  typedef struct {
    int              chan;
    int              id;
    longint unsigned data;
  } req_t;

  req_t pend[$];
  req_t p [LAT];
  bit   pv [LAT];
  int   m_ptr = NC - 1;
  bit   m_err = 0;

  int obs_chan[$];
  int obs_id[$];

  function automatic int cnt(input int c);
    int n = 0;
    foreach (pend[i]) if (pend[i].chan == c) n++;
    return n;
  endfunction

  function automatic bit exp_ready(input int c);
    if (c >= NC) return 1'b1;
    return cnt(c) < FD;
  endfunction

  task automatic model_step();
    bit   stall, acc, found;
    int   g;
    req_t e;
    if (!reset_n) begin
      pend.delete();
      for (int i = 0; i < LAT; i++) pv[i] = 0;
      m_ptr = NC - 1;
      m_err = 0;
      return;
    end
    stall = pv[LAT-1] && !rsp_ready;
    acc   = req_valid && exp_ready(int'(req_chan));
    m_err = req_valid && (int'(req_chan) >= NC);
    if (!stall) begin
      found = 0;
      g = 0;
      for (int k = 1; k <= NC; k++) begin
        if (!found && cnt((m_ptr + k) % NC) > 0) begin
          found = 1;
          g = (m_ptr + k) % NC;
        end
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        p[i]  = p[i-1];
      end
      pv[0] = found;
      if (found) begin
        for (int i = 0; i < pend.size(); i++) begin
          if (pend[i].chan == g) begin
            e = pend[i];
            pend.delete(i);
            break;
          end
        end
        p[0]  = e;
        m_ptr = g;
      end
    end
    if (acc && int'(req_chan) < NC) begin
      e.chan = int'(req_chan);
      e.id   = int'(req_id);
      e.data = longint'(req_data);
      pend.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    model_step();
  end

  initial forever begin
    longint unsigned s;
    @(negedge clock);
    if (cmp_en) begin
      chk("rsp_valid", rsp_valid, pv[LAT-1]);
      if (pv[LAT-1]) begin
        s = p[LAT-1].data + 64'd1;
        chk("rsp_chan", rsp_chan, p[LAT-1].chan);
        chk("rsp_id", rsp_id, p[LAT-1].id);
        chk("rsp_data", rsp_data, s & 64'hFFFF_FFFF);
        chk("rsp_wrap", rsp_wrap, s >> 32);
      end
      chk("req_ready", req_ready, exp_ready(int'(req_chan)));
      chk("err_badchan", err_badchan, m_err);
      for (int c = 0; c < NC; c++) chk("chan_level", chan_level[c*LW +: LW], cnt(c));
      if (reset_n && rsp_valid && rsp_ready) begin
        obs_chan.push_back(int'(rsp_chan));
        obs_id.push_back(int'(rsp_id));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int c, input int id, input logic [31:0] d);
    req_valid = 1'b1;
    req_chan  = CW'(c);
    req_id    = 8'(id);
    req_data  = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(nm, rsp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids3 [5];
    int exp_ch4  [7];
    int exp_id4  [7];
    exp_ids3 = '{8'h30, 8'h40, 8'h41, 8'h42, 8'h43};
    exp_ch4  = '{2, 0, 1, 0, 1, 0, 1};
    exp_id4  = '{8'h50, 8'h61, 8'h71, 8'h62, 8'h72, 8'h63, 8'h73};

    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_level", chan_level, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset_n = 1'b1;
    idle(2);

    // Single request: response visible exactly four cycles after acceptance.
    send(0, 8'h11, 32'd41);
    idle(2);
    chk("t1_early", rsp_valid, 0);
    idle(1);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_chan", rsp_chan, 0);
    chk("t1_id", rsp_id, 8'h11);
    chk("t1_data", rsp_data, 42);
    chk("t1_wrap", rsp_wrap, 0);
    idle(2);

    send(0, 8'h22, 32'hFFFF_FFFF);
    idle(3);
    chk("t2_valid", rsp_valid, 1);
    chk("t2_data", rsp_data, 0);
    chk("t2_wrap", rsp_wrap, 1);
    idle(3);

    // Freeze the output with one chan 0 response, then fill chan 1.
    rsp_ready = 1'b0;
    send(0, 8'h30, 32'd200);
    wait_rsp("t3_stall");
    for (int i = 0; i < 4; i++) send(1, 8'h40 + i, 32'd300 + 32'(i));
    req_chan = 2'd1;
    #1;
    chk("t3_rdy_full", req_ready, 0);
    chk("t3_lvl1", chan_level[5:3], 4);
    req_chan = 2'd0;
    #1;
    chk("t3_rdy_ch0", req_ready, 1);
    obs_chan.delete();
    obs_id.delete();
    rsp_ready = 1'b1;
    idle(12);
    chk("t3_count", obs_id.size(), 5);
    for (int i = 0; i < 5 && i < obs_id.size(); i++) chk("t3_order", obs_id[i], exp_ids3[i]);

    // Both channels queued behind a stalled chan 2 response: grants alternate from chan 0.
    rsp_ready = 1'b0;
    send(2, 8'h50, 32'd7);
    wait_rsp("t4_stall");
    for (int i = 0; i < 3; i++) begin
      send(0, 8'h61 + i, 32'd10 + 32'(i));
      send(1, 8'h71 + i, 32'd20 + 32'(i));
    end
    obs_chan.delete();
    obs_id.delete();
    rsp_ready = 1'b1;
    idle(14);
    chk("t4_count", obs_chan.size(), 7);
    for (int i = 0; i < 7 && i < obs_chan.size(); i++) begin
      chk("t4_chan", obs_chan[i], exp_ch4[i]);
      chk("t4_id", obs_id[i], exp_id4[i]);
    end

    obs_chan.delete();
    obs_id.delete();
    send(3, 8'h99, 32'd5);
    chk("t5_err_pulse", err_badchan, 1);
    idle(1);
    chk("t5_err_clear", err_badchan, 0);
    idle(8);
    chk("t5_no_rsp", obs_chan.size(), 0);
    chk("t5_level", chan_level, 0);

    // Reset mid-operation with responses in flight and entries queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 8'hA0 + i, 32'd50 + 32'(i));
    send(1, 8'hA4, 32'd60);
    chk("t6_pre_valid", rsp_valid, 1);
    chk("t6_pre_lvl0", chan_level[2:0], 1);
    chk("t6_pre_lvl1", chan_level[5:3], 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_ready", req_ready, 1);
    chk("t6_rst_level", chan_level, 0);
    chk("t6_rst_id", rsp_id, 0);
    chk("t6_rst_data", rsp_data, 0);
    chk("t6_rst_err", err_badchan, 0);
    idle(2);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    obs_chan.delete();
    obs_id.delete();
    idle(10);
    chk("t6_no_stale", obs_chan.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
